crp16_mem_arbiter: RTL and testbench

//  Shares one port (port B) of the crp16 dual-port memory between two requesters:
//  the datapath data-access unit (cpu) and a debug/loader unit (dbg).
//  It runs one transaction at a time through a req/ack handshake and sequences the RAM read latency.

---
 rtl/crp16_mem_arbiter_pkg.sv | 15 +
 rtl/crp16_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_crp16_mem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/crp16_mem_arbiter_pkg.sv
// Shared definitions for the crp16 port-B memory arbiter: FSM state encodings and owner codes.
package crp16_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;

endpackage

// File: rtl/crp16_mem_arbiter.sv
// Shares memory port B between cpu and dbg, one req/ack transaction at a time, cpu priority with dbg starvation cap.
// Ack follows the grant edge by 1 edge on writes and 1+RD_LAT edges on reads; requesters stall by holding req.
module crp16_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic [1:0]        owner
);
    import crp16_mem_arbiter_pkg::*;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [1:0] WAIT_LAST  = 2'(RD_LAT - 1);

    arb_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        owner_q, owner_d;
    logic [3:0]        starve_q, starve_d;
    logic [1:0]        wait_q, wait_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= OWN_NONE;
            starve_q    <= '0;
            wait_q      <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        // A dbg that is not asking has no claim to accumulated losses.
        if (!dbg_req) begin
            starve_d = '0;
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (cpu_req && (starve_q < STARVE_LIM)) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    owner_d = OWN_CPU;
                    state_d = ARB_ISSUE;
                    if (dbg_req) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (dbg_req) begin
                    we_d     = dbg_we;
                    addr_d   = dbg_addr;
                    wdata_d  = dbg_wdata;
                    owner_d  = OWN_DBG;
                    state_d  = ARB_ISSUE;
                    starve_d = '0;
                end
            end
            ARB_ISSUE: begin
                wait_d  = '0;
                state_d = we_q ? ARB_DONE : ARB_WAIT;
            end
            ARB_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    if (owner_q == OWN_DBG) begin
                        dbg_rdata_d = mem_q;
                    end else begin
                        cpu_rdata_d = mem_q;
                    end
                    state_d = ARB_DONE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign cpu_ack     = (state_q == ARB_DONE) && (owner_q == OWN_CPU);
    assign dbg_ack     = (state_q == ARB_DONE) && (owner_q == OWN_DBG);
    assign cpu_rdata   = cpu_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign mem_address = addr_q;
    assign mem_data    = wdata_q;
    assign mem_wren    = (state_q == ARB_ISSUE) && we_q;
    assign busy        = (state_q != ARB_IDLE);
    assign owner       = owner_q;

endmodule

// File: tb/tb_crp16_mem_arbiter.sv
// Directed and randomized bench for crp16_mem_arbiter against a transaction-level model (RD_LAT=1 and RD_LAT=3 instances).
module tb_crp16_mem_arbiter;

    localparam int SMAX = 4;

    logic clock;
    logic reset;

    logic        c_req, c_we, d_req, d_we;
    logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        cpu_ack, dbg_ack, mem_wren, busy;
    logic [15:0] cpu_rdata, dbg_rdata, mem_address, mem_data, mem_q;
    logic [1:0]  owner;

    logic        c3_req, c3_we, d3_req, d3_we;
    logic [15:0] c3_addr, c3_wdata, d3_addr, d3_wdata;
    logic        cpu_ack3, dbg_ack3, mem_wren3, busy3;
    logic [15:0] cpu_rdata3, dbg_rdata3, mem_address3, mem_data3, mem_q3;
    logic [1:0]  owner3;

    logic [15:0] ram [256];
    logic [15:0] model_mem [256];
    logic [15:0] exp_crd, exp_drd;
    int          starve;
    int          vectors, miscompares;

    crp16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .STARVE_MAX(SMAX)) u1 (
        .clock(clock), .reset(reset),
        .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(d_req), .dbg_we(d_we), .dbg_addr(d_addr), .dbg_wdata(d_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
        .busy(busy), .owner(owner)
    );

    crp16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3), .STARVE_MAX(SMAX)) u3 (
        .clock(clock), .reset(reset),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr), .dbg_wdata(d3_wdata),
        .dbg_ack(dbg_ack3), .dbg_rdata(dbg_rdata3),
        .mem_address(mem_address3), .mem_data(mem_data3), .mem_wren(mem_wren3), .mem_q(mem_q3),
        .busy(busy3), .owner(owner3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port RAM with one cycle of read latency, read-before-write.
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address[7:0]] <= mem_data;
        mem_q <= ram[mem_address[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_cpu();
        c_req   = 1'b1;
        c_we    = 1'($urandom_range(0, 1));
        c_addr  = {8'h00, 8'($urandom)};
        c_wdata = 16'($urandom);
    endtask

    task automatic new_dbg();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = {8'h00, 8'($urandom)};
        d_wdata = 16'($urandom);
    endtask

    // Called at a negedge with the DUT idle and at least one request up; returns the observed grant.
    task automatic run_round(output logic [1:0] got_owner);
        logic [1:0]  win;
        logic        we;
        logic [15:0] addr, wdata;
        int          n, wren_cycles;
        logic        done;
        if (c_req && starve < SMAX) begin
            win = 2'b01; we = c_we; addr = c_addr; wdata = c_wdata;
            starve = d_req ? starve + 1 : 0;
        end else begin
            win = 2'b10; we = d_we; addr = d_addr; wdata = d_wdata;
            starve = 0;
        end
        n = 0; wren_cycles = 0; done = 1'b0; got_owner = 2'b00;
        while (!done && n < 12) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (n == 1) begin
                got_owner = owner;
                chk("owner", owner, win);
                chk("busy_hi", busy, 1);
            end
            if (mem_wren) begin
                wren_cycles++;
                chk("wren_addr", mem_address, addr);
                chk("wren_data", mem_data, wdata);
            end
            if (cpu_ack || dbg_ack) done = 1'b1;
        end
        chk("latency", n, we ? 2 : 3);
        chk("cpu_ack", cpu_ack, win == 2'b01);
        chk("dbg_ack", dbg_ack, win == 2'b10);
        chk("wren_cycles", wren_cycles, we ? 1 : 0);
        if (we) model_mem[addr[7:0]] = wdata;
        else if (win == 2'b01) exp_crd = model_mem[addr[7:0]];
        else exp_drd = model_mem[addr[7:0]];
        chk("cpu_rdata", cpu_rdata, exp_crd);
        chk("dbg_rdata", dbg_rdata, exp_drd);
        if (win == 2'b01) c_req = 1'b0;
        else d_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("busy_lo", busy, 0);
        chk("ack_lo", {cpu_ack, dbg_ack}, 0);
    endtask

    initial begin
        logic [1:0] g;
        int n;
        vectors = 0; miscompares = 0; starve = 0;
        exp_crd = '0; exp_drd = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 16'($urandom);
            model_mem[i] = ram[i];
        end
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        c3_req = 0; c3_we = 0; c3_addr = '0; c3_wdata = '0;
        d3_req = 0; d3_we = 0; d3_addr = '0; d3_wdata = '0;
        mem_q3 = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_outputs", {cpu_ack, dbg_ack, mem_wren, busy, owner, cpu_rdata, dbg_rdata}, 0);
        chk("rst_mem", {mem_address, mem_data}, 0);
        reset = 1'b0;
        @(negedge clock);

        // cpu read of a known location
        ram[16] = 16'hBEEF; model_mem[16] = 16'hBEEF;
        c_req = 1; c_we = 0; c_addr = 16'h0010; c_wdata = 16'h0;
        run_round(g);
        chk("t1_rdata", cpu_rdata, 16'hBEEF);
        chk("t1_owner", owner, 2'b01);

        // dbg write then read back
        d_req = 1; d_we = 1; d_addr = 16'h0005; d_wdata = 16'h1234;
        run_round(g);
        d_req = 1; d_we = 0;
        run_round(g);
        chk("t2_readback", dbg_rdata, 16'h1234);

        // both held: fixed grant pattern from the starvation cap
        new_cpu(); new_dbg();
        for (int i = 0; i < 10; i++) begin
            run_round(g);
            chk("t3_order", g, (i % 5 == 4) ? 2'b10 : 2'b01);
            if (g == 2'b01) new_cpu(); else new_dbg();
        end
        c_req = 0; d_req = 0; starve = 0;
        @(negedge clock);

        // simultaneous requests with a clear counter
        new_cpu(); new_dbg();
        run_round(g);
        chk("t4_first", g, 2'b01);
        run_round(g);
        chk("t4_second", g, 2'b10);

        // reset in the middle of a read
        c_req = 1; c_we = 0; c_addr = 16'h0033;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        chk("t5_in_wait", busy, 1);
        reset = 1'b1;
        #1;
        chk("t5_async", {cpu_ack, dbg_ack, mem_wren, busy, owner, cpu_rdata, dbg_rdata}, 0);
        chk("t5_mem", {mem_address, mem_data}, 0);
        c_req = 0;
        exp_crd = '0; exp_drd = '0; starve = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t5_no_ack", {cpu_ack, dbg_ack}, 0);
        end
        reset = 1'b0;
        @(negedge clock);
        c_req = 1; c_we = 0; c_addr = 16'h0033;
        run_round(g);

        // randomized traffic
        for (int r = 0; r < 60; r++) begin
            if (!c_req && $urandom_range(0, 2) != 0) new_cpu();
            if (!d_req && $urandom_range(0, 2) != 0) new_dbg();
            if (!c_req && !d_req) new_cpu();
            run_round(g);
        end
        c_req = 0; d_req = 0;

        // RD_LAT=3: capture takes the value presented in the last wait cycle
        c3_req = 1; c3_we = 0; c3_addr = 16'h0020;
        n = 0;
        while (!cpu_ack3 && n < 12) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (n == 1) mem_q3 = 16'h1111;
            if (n == 3) mem_q3 = 16'h2222;
            if (n == 4) mem_q3 = 16'hCAFE;
        end
        chk("t6_latency", n, 5);
        chk("t6_rdata", cpu_rdata3, 16'hCAFE);
        chk("t6_owner", owner3, 2'b01);
        c3_req = 0;
        @(negedge clock);
        chk("t6_ack_lo", cpu_ack3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
